// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch payload type for the instruction front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t; flush has priority over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           push,
  input  fetch_entry_t   push_data,
  input  logic           pop,
  output fetch_entry_t   head,
  output logic [CW-1:0]  count
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, ROM request tracking, epoch-based stale-drop and prefetch FIFO.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_adress,
  input  logic [XLEN-1:0] data_in_rom,
  input  logic            fetch_enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            inflight_epoch;
  logic            epoch;
  logic            issue;
  logic            capture;
  logic            pop;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  // Conservative slot check: an in-flight word always has a slot reserved.
  assign issue   = fetch_enable && !redirect_valid &&
                   ((32'(count) + 32'(inflight)) <= (FIFO_DEPTH - 1));
  assign capture = inflight && (inflight_epoch == epoch) && !redirect_valid;
  assign pop     = instr_valid && instr_ready;

  assign push_data.instr = data_in_rom;
  assign push_data.pc    = inflight_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
      epoch    <= ~epoch;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
        fetch_pc       <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign rom_adress  = {2'b00, fetch_pc[31:2]};
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc : '0;

`ifdef FETCH_PERF_EN
  // Dropped = stale responses plus every entry discarded by a redirect flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(issue);
      perf_dropped <= perf_dropped + 32'(inflight && !capture)
                    + (redirect_valid ? 32'(count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboard of expected {instr, pc} popped on each handshake.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_adress;
  logic [31:0] data_in_rom = '0;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int vectors = 0;
  int errors  = 0;
  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  // ROM returns word data one cycle after the address.
  always @(posedge clk) data_in_rom <= 32'h1000_0000 + rom_adress;

  instr_fetch_unit #(.FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_adress     (rom_adress),
    .data_in_rom    (data_in_rom),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge after inputs are set: score the handshake of the coming edge.
  task automatic tick();
    fetch_entry_t e;
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      vectors++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed pc %h expected none", instr_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e.pc);
        chk("pop_instr", instr, e.instr);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    fetch_entry_t e;
    logic [31:0]  p;
    for (int i = 0; i < n; i++) begin
      p       = start + 32'(4 * i);
      e.pc    = p;
      e.instr = 32'h1000_0000 + {2'b00, p[31:2]};
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget && exp_q.size() > 0; k++) tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst          = 1'b0;
    fetch_enable = 1'b1;
    instr_ready  = ready;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_addr", rom_adress, 32'd0);

    // Streaming from reset: first word two edges after release, no bubbles
    do_reset(1'b1);
    push_seq(32'h0, 8);
    tick();
    chk("t1_lat_valid0", 32'(instr_valid), 32'd0);
    tick();
    chk("t1_lat_valid1", 32'(instr_valid), 32'd1);
    chk("t1_first_pc", instr_pc, 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("t1_no_bubble", 32'(instr_valid), 32'd1);
      tick();
    end
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: FIFO fills, address freezes, head held
    instr_ready = 1'b0;
    do_reset(1'b0);
    push_seq(32'h0, 5);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k >= 5) begin
        chk("t2_addr_frozen", rom_adress, 32'd4);
        chk("t2_head_pc", instr_pc, 32'd0);
        chk("t2_head_valid", 32'(instr_valid), 32'd1);
      end
    end
    instr_ready = 1'b1;
    drain("t2_drain", 20);
    instr_ready = 1'b0;

    // Redirect with three buffered entries
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk("t3_pre_pc", instr_pc, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    instr_ready    = 1'b1;
    exp_q.delete();
    push_seq(32'h100, 3);
    tick();
    redirect_valid = 1'b0;
    chk("t3_bubble1", 32'(instr_valid), 32'd0);
    tick();
    chk("t3_bubble2", 32'(instr_valid), 32'd0);
    tick();
    chk("t3_target_valid", 32'(instr_valid), 32'd1);
    chk("t3_target_pc", instr_pc, 32'h100);
    drain("t3_drain", 20);

    // Back-to-back redirects: last target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    exp_q.delete();
    push_seq(32'h40, 4);
    tick();
    redirect_pc = 32'h80;
    exp_q.delete();
    push_seq(32'h80, 4);
    tick();
    redirect_valid = 1'b0;
    drain("t4_drain", 20);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    exp_q.delete();
    push_seq(32'hFFFF_FFF8, 4);
    tick();
    redirect_valid = 1'b0;
    drain("t5_wrap_drain", 20);
    instr_ready = 1'b0;

    // Async reset with two entries buffered
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    exp_q.delete();
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_pre_valid", 32'(instr_valid), 32'd1);
    chk("t6_pre_pc", instr_pc, 32'h200);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_instr", instr, NOP_INSTR);
    chk("t6_rst_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_EN
    chk("t6_perf_fetched", perf_fetched, 32'd0);
    chk("t6_perf_dropped", perf_dropped, 32'd0);
`endif
    @(negedge clk);
    do_reset(1'b1);
    push_seq(32'h0, 3);
    drain("t6_restart_drain", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end stage directly upstream of the core. Owns the program counter, drives the word-addressed instruction ROM and buffers returned words in a small prefetch FIFO. Hands each instruction and its PC to the core over a valid/ready handshake. Accepts redirects from the core (taken branch, JAL, JALR) and flushes stale words.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries; legal range 2..16; sustained 1 instr/cycle needs >=3.
RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
rom_adress  out  32  ROM word address = {2'b00, fetch_pc[31:2]}; combinational from fetch_pc.
data_in_rom  in  32  ROM data; valid exactly one cycle after the address is presented.
fetch_enable  in  1  0 = issue no new ROM requests; in-flight data still captured.
redirect_valid  in  1  1-cycle pulse: restart fetch at redirect_pc.
redirect_pc  in  32  byte target; bits [1:0] ignored (forced 0).
instr_valid  out  1  FIFO head valid.
instr_ready  in  1  core accepts head this cycle.
instr  out  32  FIFO head instruction word.
instr_pc  out  32  byte PC of instr.

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, FIFO empty (count=0, pointers 0), inflight=0, epoch=0; instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0.
- Issue rule: request issued in a cycle iff fetch_enable && !redirect_valid && (count + inflight) <= FIFO_DEPTH-1. Conservative: a same-cycle pop does not free a slot.
- On issue: inflight<=1, inflight_pc<=fetch_pc, inflight_epoch<=epoch, fetch_pc<=fetch_pc+4. fetch_pc wraps 32'hFFFF_FFFC -> 0.
- On no issue: inflight<=0.
- Capture: if inflight && inflight_epoch==epoch && !redirect_valid, push {data_in_rom, inflight_pc} at the cycle end. Overflow cannot occur by construction; an assertion fires if a push would exceed FIFO_DEPTH.
- Pop on instr_valid && instr_ready. Push and pop in the same cycle: count unchanged, both pointers advance modulo FIFO_DEPTH.
- Latency: issue in cycle N -> push at end of N+1 -> instr_valid in N+2. First instruction after reset release is visible 2 cycles after the first clk edge with rst low.
- Redirect (redirect_valid=1 in cycle R), priority over all else:
  - FIFO cleared (count=0); any pop in R is void; epoch toggles; inflight<=0; fetch_pc<={redirect_pc[31:2],2'b00}.
  - No issue in R; first target request issued R+1; target word valid R+3.
  - instr_valid=0 in R+1 and R+2.
  - A response returning in R+1 carries the old epoch and is dropped.
- Back-to-back redirects: the last one wins; every earlier target is discarded.
- fetch_enable low: pipeline drains into the FIFO; head held while instr_ready=0.
- Output stability: instr/instr_pc remain constant while instr_valid && !instr_ready.

Optional Feature:
FETCH_PERF_EN defined: adds outputs perf_fetched (32) and perf_dropped (32). perf_fetched counts issued requests; perf_dropped counts stale responses plus FIFO entries flushed by redirect. Both wrap at 2^32 and reset to 0. Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- riscv_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, ...), fetch_entry_t {instr, pc}.
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t parameterised by depth with push/pop/flush/count. Flush has priority over push.

Test Plan:
- Reset release, ROM[i]=32'h1000_0000+i, instr_ready=1 -> instr_valid from cycle 2; pc 0,4,8,... with instr 32'h1000_0000,..._0001,..._0002; one per cycle, no bubbles.
- instr_ready=0 for 10 cycles, FIFO_DEPTH=4 -> count saturates at 4; rom_adress freezes; head stays pc=0. Release -> pcs 0,4,8,12,16 in order, no loss or duplication.
- Redirect to 32'h0000_0103 while FIFO holds 3 entries -> instr_valid low 2 cycles; next output pc=32'h100, instr=ROM[64]; stale word never delivered.
- Redirects in consecutive cycles to 0x40 then 0x80 -> first delivered pc=0x80; 0x40 never appears.
- fetch_pc at 32'hFFFF_FFF8 -> delivers 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted mid-stream with 2 entries buffered -> outputs immediately instr_valid=0, instr=32'h13; restart delivers pc=RESET_PC. With FETCH_PERF_EN, counters read 0.
